axis_uart_tx_arbiter: RTL and testbench

AXIS_UART_TX_ARBITER -- requirements
Module: axis_uart_tx_arbiter

---
 rtl/axis_uart_tx_arbiter_if.sv | 28 ++
 rtl/axis_uart_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_axis_uart_tx_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_uart_tx_arbiter_if.sv
// AXI-Stream bundle between N requesters and one UART TX stream slave.
// The arbiter connects through the slave modport, and the requester/sink side
// connects through the master modport.
interface axis_uart_tx_arbiter_if #(
  parameter int unsigned N_PORTS    = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned ID_W = $clog2(N_PORTS);

  logic [N_PORTS*DATA_WIDTH-1:0] s_tdata;
  logic [N_PORTS-1:0]            s_tvalid;
  logic [N_PORTS-1:0]            s_tlast;
  logic [N_PORTS-1:0]            s_tready;
  logic [DATA_WIDTH-1:0]         m_tdata;
  logic                          m_tvalid;
  logic                          m_tready;
  logic [ID_W-1:0]               m_tid;

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tid
  );

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tid
  );
endinterface

// File: rtl/axis_uart_tx_arbiter.sv
// Round-robin arbiter that merges N AXI-Stream requesters onto one UART TX
// stream through a one-entry output register slice.
// Optional macro ARB_PACKET_LOCK_EN: hold the grant until the tlast beat so
// messages are never interleaved; when undefined the grant is released after
// every accepted beat and s_tlast is ignored.
module axis_uart_tx_arbiter #(
  parameter int unsigned N_PORTS    = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  axis_uart_tx_arbiter_if.slave  bus,
  output logic                   busy
);
  localparam int unsigned ID_W = $clog2(N_PORTS);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e                state_q, state_d;
  logic [ID_W-1:0]       grant_q, grant_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]       winner, cand;
  logic                  win_found;
  logic [N_PORTS-1:0]    s_tready;
  logic                  src_hs;
  logic                  grant_done;
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic [ID_W-1:0]       m_tid_q, m_tid_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic [DATA_WIDTH-1:0] s_data_arr [N_PORTS];

  for (genvar g = 0; g < N_PORTS; g++) begin : g_unpack
    assign s_data_arr[g] = bus.s_tdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

`ifndef ARB_PACKET_LOCK_EN
  logic unused_tlast;
  assign unused_tlast = ^bus.s_tlast;
`endif

  // Round-robin search from rr_ptr upward; scanning downward lets the
  // nearest requester overwrite farther ones without an early exit.
  always_comb begin
    winner    = rr_ptr_q;
    win_found = 1'b0;
    cand      = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      cand = ID_W'((int'(rr_ptr_q) + i) % int'(N_PORTS));
      if (bus.s_tvalid[cand]) begin
        winner    = cand;
        win_found = 1'b1;
      end
    end
  end

  // Grant FSM next state, per-port ready and grant release.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    s_tready   = '0;
    src_hs     = 1'b0;
    grant_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StGrant;
          grant_d = winner;
        end
      end
      StGrant: begin
        s_tready[grant_q] = !m_tvalid_q || bus.m_tready;
        src_hs            = bus.s_tvalid[grant_q] && s_tready[grant_q];
`ifdef ARB_PACKET_LOCK_EN
        grant_done        = src_hs && bus.s_tlast[grant_q];
`else
        grant_done        = src_hs;
`endif
        if (grant_done) begin
          state_d  = StIdle;
          rr_ptr_d = (grant_q == ID_W'(N_PORTS - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output slice: a load wins over a drain so back-to-back beats have no bubble.
  always_comb begin
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tid_d    = m_tid_q;
    if (src_hs) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = s_data_arr[grant_q];
      m_tid_d    = grant_q;
    end else if (m_tvalid_q && bus.m_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  // State and slice registers; reset drops any held beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tid_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tid_q    <= m_tid_d;
    end
  end

  assign bus.s_tready = s_tready;
  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tvalid = m_tvalid_q;
  assign bus.m_tid    = m_tid_q;
  assign busy         = (state_q != StIdle) || m_tvalid_q;
endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Directed bench for axis_uart_tx_arbiter (4 ports, 8-bit beats).
module tb_axis_uart_tx_arbiter;
  logic aclk;
  logic aresetn;
  logic busy;

  axis_uart_tx_arbiter_if #(.N_PORTS(4), .DATA_WIDTH(8)) tb_if ();

  axis_uart_tx_arbiter #(.N_PORTS(4), .DATA_WIDTH(8)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (tb_if),
    .busy    (busy)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int total;
  int bad;
  int cyc;
  int out_cnt;

  // Per-port source beat lists.
  logic [7:0] src_data [4][8];
  logic       src_last [4][8];
  int         src_len  [4];
  int         src_pos  [4];
  logic [3:0] hs;

  // Beats accepted by the sink.
  logic [1:0] out_tid  [8];
  logic [7:0] out_data [8];
  int         out_cyc  [8];

  task automatic drive();
    logic [7:0] b [4];
    logic [3:0] v;
    logic [3:0] l;
    v = '0;
    l = '0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] p;
      logic [2:0] k;
      p    = 2'(i);
      k    = 3'(src_pos[p]);
      b[p] = 8'h00;
      if (src_pos[p] < src_len[p]) begin
        v[p] = 1'b1;
        b[p] = src_data[p][k];
        l[p] = src_last[p][k];
      end
    end
    tb_if.s_tvalid = v;
    tb_if.s_tlast  = l;
    tb_if.s_tdata  = {b[3], b[2], b[1], b[0]};
  endtask

  // One clock: sample handshakes just before the edge, advance sources after it.
  task automatic step();
    logic [2:0] oi;
    #1;
    hs = tb_if.s_tvalid & tb_if.s_tready;
    if (tb_if.m_tvalid && tb_if.m_tready && out_cnt < 8) begin
      oi           = 3'(out_cnt);
      out_tid[oi]  = tb_if.m_tid;
      out_data[oi] = tb_if.m_tdata;
      out_cyc[oi]  = cyc;
      out_cnt++;
    end
    @(posedge aclk);
    cyc++;
    #1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] p;
      p = 2'(i);
      if (hs[p]) src_pos[p]++;
    end
    drive();
    @(negedge aclk);
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] p;
      p          = 2'(i);
      src_len[p] = 0;
      src_pos[p] = 0;
    end
    hs      = '0;
    out_cnt = 0;
    drive();
  endtask

  task automatic set_src(input int port, input int n, input logic [7:0] d0,
                         input logic [7:0] d1, input logic [7:0] d2, input logic lock_last);
    logic [1:0] p;
    p              = 2'(port);
    src_len[p]     = n;
    src_pos[p]     = 0;
    src_data[p][0] = d0;
    src_data[p][1] = d1;
    src_data[p][2] = d2;
    // lock_last: tlast only on the final beat; otherwise every beat is a message
    src_last[p][0] = lock_last ? (n == 1) : 1'b1;
    src_last[p][1] = lock_last ? (n == 2) : 1'b1;
    src_last[p][2] = lock_last ? (n == 3) : 1'b1;
  endtask

  // Ends at the falling edge of the first cycle after release.
  task automatic do_reset();
    aresetn        = 1'b0;
    tb_if.m_tready = 1'b0;
    clear_all();
    @(posedge aclk);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (tb_if.s_tready !== 4'b0000 || busy !== 1'b0 || tb_if.m_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: s_tready=%b busy=%b m_tvalid=%b want 0000/0/0",
               tb_if.s_tready, busy, tb_if.m_tvalid);
    end
    total++;
    if (tb_if.m_tdata !== 8'h00 || tb_if.m_tid !== 2'd0) begin
      bad++;
      $display("FAIL reset_data: m_tdata=%h m_tid=%0d want 00/0", tb_if.m_tdata, tb_if.m_tid);
    end
    // Hold a beat under backpressure, then reset mid-beat.
    set_src(3, 1, 8'h99, 8'h00, 8'h00, 1'b0);
    drive();
    step();
    step();
    total++;
    if (tb_if.m_tvalid !== 1'b1 || tb_if.m_tdata !== 8'h99) begin
      bad++;
      $display("FAIL reset_pre_beat: m_tvalid=%b m_tdata=%h want 1/99",
               tb_if.m_tvalid, tb_if.m_tdata);
    end
    #2;
    aresetn = 1'b0;
    #1;
    total++;
    if (tb_if.m_tvalid !== 1'b0 || tb_if.s_tready !== 4'b0000 || busy !== 1'b0 ||
        tb_if.m_tdata !== 8'h00) begin
      bad++;
      $display("FAIL reset_async: m_tvalid=%b s_tready=%b busy=%b m_tdata=%h want 0/0000/0/00",
               tb_if.m_tvalid, tb_if.s_tready, busy, tb_if.m_tdata);
    end
    clear_all();
    tb_if.m_tready = 1'b1;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    total++;
    if (tb_if.s_tready !== 4'b0000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: s_tready=%b busy=%b want 0000/0", tb_if.s_tready, busy);
    end
    repeat (4) step();
    total++;
    if (out_cnt !== 0) begin
      bad++;
      $display("FAIL reset_no_stale_beat: beats=%0d want 0", out_cnt);
    end
  endtask

  task automatic test_single();
    do_reset();
    tb_if.m_tready = 1'b1;
    set_src(2, 1, 8'hA5, 8'h00, 8'h00, 1'b0);
    total++;
    if (tb_if.s_tready !== 4'b0000) begin
      bad++;
      $display("FAIL single_idle_ready: s_tready=%b want 0000", tb_if.s_tready);
    end
    drive();
    step();
    total++;
    if (tb_if.s_tready !== 4'b0100 || tb_if.m_tvalid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: s_tready=%b m_tvalid=%b busy=%b want 0100/0/1",
               tb_if.s_tready, tb_if.m_tvalid, busy);
    end
    step();
    total++;
    if (tb_if.m_tvalid !== 1'b1 || tb_if.m_tdata !== 8'hA5 || tb_if.m_tid !== 2'd2) begin
      bad++;
      $display("FAIL single_output: m_tvalid=%b m_tdata=%h m_tid=%0d want 1/a5/2",
               tb_if.m_tvalid, tb_if.m_tdata, tb_if.m_tid);
    end
    total++;
    if (tb_if.s_tready !== 4'b0000) begin
      bad++;
      $display("FAIL single_release: s_tready=%b want 0000", tb_if.s_tready);
    end
    step();
    total++;
    if (tb_if.m_tvalid !== 1'b0 || busy !== 1'b0 || out_cnt !== 1) begin
      bad++;
      $display("FAIL single_drain: m_tvalid=%b busy=%b beats=%0d want 0/0/1",
               tb_if.m_tvalid, busy, out_cnt);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_tid  [8];
    logic [7:0] exp_data [8];
    int         gap_err;
    exp_tid  = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd0};
    exp_data = '{8'h00, 8'h10, 8'h30, 8'h01, 8'h11, 8'h31, 8'h00, 8'h00};
    do_reset();
    tb_if.m_tready = 1'b1;
    set_src(0, 2, 8'h00, 8'h01, 8'h00, 1'b0);
    set_src(1, 2, 8'h10, 8'h11, 8'h00, 1'b0);
    set_src(3, 2, 8'h30, 8'h31, 8'h00, 1'b0);
    drive();
    repeat (16) step();
    total++;
    if (out_cnt !== 6) begin
      bad++;
      $display("FAIL rr_count: beats=%0d want 6", out_cnt);
    end
    for (int j = 0; j < 6; j++) begin
      logic [2:0] jj;
      jj = 3'(j);
      total++;
      if (out_tid[jj] !== exp_tid[jj] || out_data[jj] !== exp_data[jj]) begin
        bad++;
        $display("FAIL rr_beat%0d: tid=%0d data=%h want %0d/%h",
                 j, out_tid[jj], out_data[jj], exp_tid[jj], exp_data[jj]);
      end
    end
    // One IDLE cycle between grants: beats land every second cycle.
    gap_err = 0;
    for (int j = 0; j < 5; j++) begin
      logic [2:0] jj;
      jj = 3'(j);
      if (out_cyc[jj + 3'd1] - out_cyc[jj] != 2) gap_err++;
    end
    total++;
    if (gap_err !== 0) begin
      bad++;
      $display("FAIL rr_idle_gap: bad gaps=%0d want 0", gap_err);
    end
  endtask

  task automatic test_backpressure();
    int         err;
    logic [7:0] first_data;
    logic [1:0] first_tid;
    logic [3:0] first_rdy;
    do_reset();
    set_src(0, 1, 8'h3C, 8'h00, 8'h00, 1'b0);
    set_src(1, 1, 8'h55, 8'h00, 8'h00, 1'b0);
    drive();
    repeat (3) step();
    err        = 0;
    first_data = 8'h00;
    first_tid  = 2'd0;
    first_rdy  = 4'b0000;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (tb_if.m_tvalid !== 1'b1 || tb_if.m_tdata !== 8'h3C || tb_if.m_tid !== 2'd0 ||
          tb_if.s_tready !== 4'b0000 || busy !== 1'b1) begin
        if (err == 0) begin
          first_data = tb_if.m_tdata;
          first_tid  = tb_if.m_tid;
          first_rdy  = tb_if.s_tready;
        end
        err++;
      end
    end
    total++;
    if (err !== 0) begin
      bad++;
      $display("FAIL bp_hold: %0d bad cycles, first m_tdata=%h m_tid=%0d s_tready=%b want 3c/0/0000",
               err, first_data, first_tid, first_rdy);
    end
    tb_if.m_tready = 1'b1;
    repeat (3) step();
    total++;
    if (out_cnt !== 2 || out_tid[0] !== 2'd0 || out_data[0] !== 8'h3C ||
        out_tid[1] !== 2'd1 || out_data[1] !== 8'h55) begin
      bad++;
      $display("FAIL bp_release: beats=%0d %0d:%h %0d:%h want 2 0:3c 1:55",
               out_cnt, out_tid[0], out_data[0], out_tid[1], out_data[1]);
    end
    total++;
    if (out_cyc[1] - out_cyc[0] !== 1) begin
      bad++;
      $display("FAIL bp_no_bubble: gap=%0d want 1", out_cyc[1] - out_cyc[0]);
    end
  endtask

  task automatic test_packet_policy();
    logic [1:0] exp_tid  [8];
    logic [7:0] exp_data [8];
`ifdef ARB_PACKET_LOCK_EN
    exp_tid  = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    exp_data = '{8'h11, 8'h22, 8'h33, 8'h0A, 8'h0B, 8'h0C, 8'h00, 8'h00};
`else
    exp_tid  = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
    exp_data = '{8'h11, 8'h0A, 8'h22, 8'h0B, 8'h33, 8'h0C, 8'h00, 8'h00};
`endif
    do_reset();
    tb_if.m_tready = 1'b1;
    set_src(1, 3, 8'h11, 8'h22, 8'h33, 1'b1);
    drive();
    step();
    // Port 0 turns valid only after port 1 holds the grant.
    set_src(0, 3, 8'h0A, 8'h0B, 8'h0C, 1'b0);
    drive();
    repeat (20) step();
    total++;
    if (out_cnt !== 6) begin
      bad++;
      $display("FAIL pkt_count: beats=%0d want 6", out_cnt);
    end
    for (int j = 0; j < 6; j++) begin
      logic [2:0] jj;
      jj = 3'(j);
      total++;
      if (out_tid[jj] !== exp_tid[jj] || out_data[jj] !== exp_data[jj]) begin
        bad++;
        $display("FAIL pkt_beat%0d: tid=%0d data=%h want %0d/%h",
                 j, out_tid[jj], out_data[jj], exp_tid[jj], exp_data[jj]);
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    cyc     = 0;
    out_cnt = 0;
    aresetn = 1'b0;
    hs      = '0;
    tb_if.m_tready = 1'b0;
    clear_all();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_packet_policy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
